// File: rtl/cordic_vector_iter_if.sv
// Handshake bundle between a sample producer/result consumer (master) and the
// CORDIC vectoring engine (slave): valid/ready on the sample side and on the result side.
interface cordic_vector_iter_if #(
    parameter int DATA_W  = 16,
    parameter int ANGLE_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] x_in;
    logic signed [DATA_W-1:0] y_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [ANGLE_W-1:0]       angle;
    logic [DATA_W+1:0]        magnitude;
    logic                     busy;

    modport master (
        output in_valid, x_in, y_in, out_ready,
        input  in_ready, out_valid, angle, magnitude, busy
    );

    modport slave (
        input  in_valid, x_in, y_in, out_ready,
        output in_ready, out_valid, angle, magnitude, busy
    );
endinterface

// File: rtl/cordic_vector_iter.sv
// Iterative CORDIC vectoring engine: (x, y) -> full-circle binary angle and
// gain-compensated magnitude, one micro-rotation per clock.
module cordic_vector_iter #(
    parameter int DATA_W    = 16,
    parameter int ANGLE_W   = 16,
    parameter int ITER      = 12,
    parameter bit GAIN_COMP = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    cordic_vector_iter_if.slave bus
);
    localparam int          XW       = DATA_W + 2;
    localparam int          ITW      = $clog2(ITER);
    localparam logic [15:0] INV_GAIN = 16'd39797;

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_e;

    state_e state_q, state_d;

    logic signed [XW-1:0] xr_q, xr_d;
    logic signed [XW-1:0] yr_q, yr_d;
    logic [ANGLE_W-1:0]   zr_q, zr_d;
    logic [ITW-1:0]       iter_q, iter_d;
    logic                 zero_q, zero_d;
    logic [ANGLE_W-1:0]   angle_q, angle_d;
    logic [XW-1:0]        mag_q, mag_d;

    logic                 accept;
    logic                 last_iter;
    logic signed [XW-1:0] x_ext, y_ext;
    logic signed [XW-1:0] x_sh, y_sh;
    logic signed [XW-1:0] x_rot, y_rot;
    logic [ANGLE_W-1:0]   a_step, z_rot;
    logic [XW+15:0]       mag_prod;
    logic [XW-1:0]        mag_calc;

    // atan(2^-i) as a fraction of a full turn, scaled by 2^32.
    function automatic logic [31:0] atan_raw(input logic [4:0] idx);
        logic [31:0] v;
        case (idx)
            5'd0:    v = 32'd536870912;
            5'd1:    v = 32'd316933406;
            5'd2:    v = 32'd167458907;
            5'd3:    v = 32'd85004756;
            5'd4:    v = 32'd42667331;
            5'd5:    v = 32'd21354465;
            5'd6:    v = 32'd10679838;
            5'd7:    v = 32'd5340245;
            5'd8:    v = 32'd2670163;
            5'd9:    v = 32'd1335087;
            5'd10:   v = 32'd667544;
            5'd11:   v = 32'd333772;
            5'd12:   v = 32'd166886;
            5'd13:   v = 32'd83443;
            5'd14:   v = 32'd41722;
            5'd15:   v = 32'd20861;
            5'd16:   v = 32'd10430;
            5'd17:   v = 32'd5215;
            5'd18:   v = 32'd2608;
            5'd19:   v = 32'd1304;
            5'd20:   v = 32'd652;
            5'd21:   v = 32'd326;
            5'd22:   v = 32'd163;
            5'd23:   v = 32'd81;
            default: v = 32'd0;
        endcase
        return v;
    endfunction

    // Round-to-nearest reduction of the 32-bit table entry to ANGLE_W bits.
    function automatic logic [ANGLE_W-1:0] atan_step(input logic [4:0] idx);
        logic [32:0] acc;
        acc = {1'b0, atan_raw(idx)} + (33'd1 << (31 - ANGLE_W));
        return ANGLE_W'(acc >> (32 - ANGLE_W));
    endfunction

    // Sign-extend by two bits first so that negating the most negative input cannot overflow.
    assign x_ext = {{2{bus.x_in[DATA_W-1]}}, bus.x_in};
    assign y_ext = {{2{bus.y_in[DATA_W-1]}}, bus.y_in};

    assign accept    = (state_q == IDLE) && bus.in_valid;
    assign last_iter = (state_q == ROTATE) && (iter_q == ITW'(ITER - 1));

    assign x_sh   = xr_q >>> iter_q;
    assign y_sh   = yr_q >>> iter_q;
    assign a_step = atan_step(5'(iter_q));

    // One micro-rotation driving yr toward zero; both updates use pre-iteration values.
    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        x_rot = xr_q;
        y_rot = yr_q;
        z_rot = zr_q;
        if (!yr_q[XW-1]) begin
            x_rot = xr_q + y_sh;
            y_rot = yr_q - x_sh;
            z_rot = zr_q + a_step;
        end else begin
            x_rot = xr_q - y_sh;
            y_rot = yr_q + x_sh;
            z_rot = zr_q - a_step;
        end
    end

    // xr stays non-negative after pre-rotation, so it can be treated as unsigned here.
    assign mag_prod = (XW + 16)'($unsigned(x_rot)) * (XW + 16)'(INV_GAIN);
    assign mag_calc = GAIN_COMP ? mag_prod[XW+15:16] : $unsigned(x_rot);

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = ROTATE;
            ROTATE:  if (last_iter)     state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b1;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                bus.busy     = 1'b0;
            end
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        xr_d    = xr_q;
        yr_d    = yr_q;
        zr_d    = zr_q;
        iter_d  = iter_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        mag_d   = mag_q;
        if (accept) begin
            // Left half-plane: rotate by 180 degrees so the iterations only cover +/-90.
            if (bus.x_in[DATA_W-1]) begin
                xr_d = -x_ext;
                yr_d = -y_ext;
                zr_d = {1'b1, {(ANGLE_W - 1){1'b0}}};
            end else begin
                xr_d = x_ext;
                yr_d = y_ext;
                zr_d = '0;
            end
            zero_d = (bus.x_in == '0) && (bus.y_in == '0);
            iter_d = '0;
        end else if (state_q == ROTATE) begin
            xr_d   = x_rot;
            yr_d   = y_rot;
            zr_d   = z_rot;
            iter_d = iter_q + 1'b1;
            if (last_iter) begin
                angle_d = zero_q ? '0 : z_rot;
                mag_d   = zero_q ? '0 : mag_calc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr_q    <= '0;
            yr_q    <= '0;
            zr_q    <= '0;
            iter_q  <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            mag_q   <= '0;
        end else begin
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            zr_q    <= zr_d;
            iter_q  <= iter_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            mag_q   <= mag_d;
        end
    end

    assign bus.angle     = angle_q;
    assign bus.magnitude = mag_q;
endmodule
